// File: rtl/pipe_fwd_regs.sv
// pipe_fwd_regs
// ------------------------------------------------------------------------
// Datapath half of the pipelined CPU. It holds the ID/EX, EX/MEM and
// MEM/WB pipeline registers, builds the forwarded ALU operands and store
// data, and hands the EX/MEM destination information back to the
// control unit so it can detect hazards.
//
// Configuration macro:
//   FWD_WB_EN  - when defined, a register-file operand (select 00) and the
//                store data take wb_wdata if the source register matches
//                the instruction being written back. This adds input id_rs.
//                When undefined the register file must write-through.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_wir              ID/EX load enable (0 = stall, load a bubble)
//   id_sela, id_selb    operand selects (00 reg, 01 sa/imm, 10 EX, 11 MEM)
//   id_wreg/m2reg/wmem  decoded ID controls
//   id_aluc             ALU op
//   id_wn, id_rt        ID destination and rt register numbers
//   id_rs               ID rs register number (FWD_WB_EN only)
//   id_qa, id_qb        register-file read data
//   id_sa, id_imm       extended shift amount and immediate
//   ex_alu_r            ALU result of the instruction in EX
//   mem_rdata           data-memory read data of the instruction in MEM
//   ex_*, EX*           ID/EX register outputs
//   mem_*, MEM*         EX/MEM register outputs
//   wb_*                MEM/WB register outputs (register-file write port)
// ------------------------------------------------------------------------
module pipe_fwd_regs #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_wir,
    input  logic [1:0]    id_sela,
    input  logic [1:0]    id_selb,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          id_wmem,
    input  logic [3:0]    id_aluc,
    input  logic [RW-1:0] id_wn,
    input  logic [RW-1:0] id_rt,
`ifdef FWD_WB_EN
    input  logic [RW-1:0] id_rs,
`endif
    input  logic [DW-1:0] id_qa,
    input  logic [DW-1:0] id_qb,
    input  logic [DW-1:0] id_sa,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] ex_alu_r,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [3:0]    ex_aluc,
    output logic [DW-1:0] ex_sdata,
    output logic          EXwreg,
    output logic          EXm2reg,
    output logic [RW-1:0] EXwn,
    output logic          mem_wmem,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_sdata,
    output logic          MEMwreg,
    output logic [RW-1:0] MEMwn,
    output logic          wb_wreg,
    output logic [RW-1:0] wb_wn,
    output logic [DW-1:0] wb_wdata
);

    // ID/EX stage registers
    logic [DW-1:0] ex_a_q, ex_a_d;
    logic [DW-1:0] ex_b_q, ex_b_d;
    logic [DW-1:0] ex_sdata_q, ex_sdata_d;
    logic [3:0]    ex_aluc_q, ex_aluc_d;
    logic          ex_wreg_q, ex_wreg_d;
    logic          ex_m2reg_q, ex_m2reg_d;
    logic          ex_wmem_q, ex_wmem_d;
    logic [RW-1:0] ex_wn_q, ex_wn_d;

    // EX/MEM stage registers
    logic          mem_wreg_q, mem_wreg_d;
    logic          mem_m2reg_q, mem_m2reg_d;
    logic          mem_wmem_q, mem_wmem_d;
    logic [RW-1:0] mem_wn_q, mem_wn_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_sdata_q, mem_sdata_d;

    // MEM/WB stage registers
    logic          wb_wreg_q, wb_wreg_d;
    logic [RW-1:0] wb_wn_q, wb_wn_d;
    logic [DW-1:0] wb_wdata_q, wb_wdata_d;

    // Combinational operand network
    logic [DW-1:0] memFwd;
    logic [DW-1:0] regA;
    logic [DW-1:0] regB;
    logic [DW-1:0] muxA;
    logic [DW-1:0] muxB;
    logic [DW-1:0] storeData;

    // The value the MEM-stage instruction will write back: the loaded word
    // for a load, otherwise the ALU result it carries as its address.
    assign memFwd = mem_m2reg_q ? mem_rdata : mem_addr_q;

    // Register-file operands, optionally bypassed from the write-back stage
    // so the register file itself does not need write-through.
    always_comb begin
        regA = id_qa;
        regB = id_qb;
`ifdef FWD_WB_EN
        if (wb_wreg_q && (id_rs == wb_wn_q)) begin
            regA = wb_wdata_q;
        end
        if (wb_wreg_q && (id_rt == wb_wn_q)) begin
            regB = wb_wdata_q;
        end
`endif
    end

    // Operand selection driven by the control unit's select codes.
    always_comb begin
        muxA = regA;
        muxB = regB;
        case (id_sela)
            2'b00:   muxA = regA;
            2'b01:   muxA = id_sa;
            2'b10:   muxA = ex_alu_r;
            default: muxA = memFwd;
        endcase
        case (id_selb)
            2'b00:   muxB = regB;
            2'b01:   muxB = id_imm;
            2'b10:   muxB = ex_alu_r;
            default: muxB = memFwd;
        endcase
    end

    // Store data only needs a MEM forward: a dependency on the EX stage is
    // resolved by the control unit stalling, never by this path.
    always_comb begin
        storeData = regB;
        if (mem_wreg_q && (id_rt == mem_wn_q)) begin
            storeData = memFwd;
        end
    end

    // Next-state for all three stages. A stalled ID/EX loads an all-zero
    // bubble; EX/MEM and MEM/WB always advance so the pipe keeps draining.
    always_comb begin
        ex_a_d      = '0;
        ex_b_d      = '0;
        ex_sdata_d  = '0;
        ex_aluc_d   = '0;
        ex_wreg_d   = 1'b0;
        ex_m2reg_d  = 1'b0;
        ex_wmem_d   = 1'b0;
        ex_wn_d     = '0;
        if (id_wir) begin
            ex_a_d     = muxA;
            ex_b_d     = muxB;
            ex_sdata_d = storeData;
            ex_aluc_d  = id_aluc;
            ex_wreg_d  = id_wreg;
            ex_m2reg_d = id_m2reg;
            ex_wmem_d  = id_wmem;
            ex_wn_d    = id_wn;
        end

        mem_wreg_d  = ex_wreg_q;
        mem_m2reg_d = ex_m2reg_q;
        mem_wmem_d  = ex_wmem_q;
        mem_wn_d    = ex_wn_q;
        mem_addr_d  = ex_alu_r;
        mem_sdata_d = ex_sdata_q;

        wb_wreg_d   = mem_wreg_q;
        wb_wn_d     = mem_wn_q;
        wb_wdata_d  = memFwd;
    end

    // Pipeline registers; reset clears every stage to a bubble and takes
    // priority over a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_sdata_q  <= '0;
            ex_aluc_q   <= '0;
            ex_wreg_q   <= 1'b0;
            ex_m2reg_q  <= 1'b0;
            ex_wmem_q   <= 1'b0;
            ex_wn_q     <= '0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            mem_wmem_q  <= 1'b0;
            mem_wn_q    <= '0;
            mem_addr_q  <= '0;
            mem_sdata_q <= '0;
            wb_wreg_q   <= 1'b0;
            wb_wn_q     <= '0;
            wb_wdata_q  <= '0;
        end else begin
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_sdata_q  <= ex_sdata_d;
            ex_aluc_q   <= ex_aluc_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_m2reg_q  <= ex_m2reg_d;
            ex_wmem_q   <= ex_wmem_d;
            ex_wn_q     <= ex_wn_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
            mem_wmem_q  <= mem_wmem_d;
            mem_wn_q    <= mem_wn_d;
            mem_addr_q  <= mem_addr_d;
            mem_sdata_q <= mem_sdata_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wn_q     <= wb_wn_d;
            wb_wdata_q  <= wb_wdata_d;
        end
    end

    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_aluc   = ex_aluc_q;
    assign ex_sdata  = ex_sdata_q;
    assign EXwreg    = ex_wreg_q;
    assign EXm2reg   = ex_m2reg_q;
    assign EXwn      = ex_wn_q;
    assign mem_wmem  = mem_wmem_q;
    assign mem_addr  = mem_addr_q;
    assign mem_sdata = mem_sdata_q;
    assign MEMwreg   = mem_wreg_q;
    assign MEMwn     = mem_wn_q;
    assign wb_wreg   = wb_wreg_q;
    assign wb_wn     = wb_wn_q;
    assign wb_wdata  = wb_wdata_q;

endmodule

// File: tb/tb_pipe_fwd_regs.sv
// tb_pipe_fwd_regs
// ------------------------------------------------------------------------
// Directed bench for pipe_fwd_regs. A history model records, for every
// clock edge, the instruction that entered EX and the ALU/memory values
// presented on that edge; the expected stage contents are read from that
// history by age. Directed vectors add literal expectations on top.
// ------------------------------------------------------------------------
module tb_pipe_fwd_regs;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic [4:0]  wn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sdata;
    } Stage_t;

    typedef struct {
        logic        rst;
        logic        wir;
        logic [1:0]  sela;
        logic [1:0]  selb;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic [4:0]  wn;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] sa;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] rdata;
    } StimVec_t;

    logic        clk;
    logic        rst;
    logic        id_wir;
    logic [1:0]  id_sela;
    logic [1:0]  id_selb;
    logic        id_wreg;
    logic        id_m2reg;
    logic        id_wmem;
    logic [3:0]  id_aluc;
    logic [4:0]  id_wn;
    logic [4:0]  id_rt;
    logic [4:0]  id_rs;
    logic [31:0] id_qa;
    logic [31:0] id_qb;
    logic [31:0] id_sa;
    logic [31:0] id_imm;
    logic [31:0] ex_alu_r;
    logic [31:0] mem_rdata;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_aluc;
    logic [31:0] ex_sdata;
    logic        EXwreg;
    logic        EXm2reg;
    logic [4:0]  EXwn;
    logic        mem_wmem;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        MEMwreg;
    logic [4:0]  MEMwn;
    logic        wb_wreg;
    logic [4:0]  wb_wn;
    logic [31:0] wb_wdata;

    int checks = 0;
    int errors = 0;
    logic checkEnable = 1'b0;

    Stage_t      hist[$];
    logic [31:0] aluH[$];
    logic [31:0] rdH[$];

    pipe_fwd_regs #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .id_wir(id_wir),
        .id_sela(id_sela), .id_selb(id_selb),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_aluc(id_aluc), .id_wn(id_wn), .id_rt(id_rt),
`ifdef FWD_WB_EN
        .id_rs(id_rs),
`endif
        .id_qa(id_qa), .id_qb(id_qb), .id_sa(id_sa), .id_imm(id_imm),
        .ex_alu_r(ex_alu_r), .mem_rdata(mem_rdata),
        .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc), .ex_sdata(ex_sdata),
        .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwn(EXwn),
        .mem_wmem(mem_wmem), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .MEMwreg(MEMwreg), .MEMwn(MEMwn),
        .wb_wreg(wb_wreg), .wb_wn(wb_wn), .wb_wdata(wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic StimVec_t nopVec();
        StimVec_t v;
        v.rst = 1'b0; v.wir = 1'b1; v.sela = 2'b00; v.selb = 2'b00;
        v.wreg = 1'b0; v.m2reg = 1'b0; v.wmem = 1'b0; v.aluc = 4'd0;
        v.wn = 5'd0; v.rt = 5'd0; v.rs = 5'd0;
        v.qa = 32'd0; v.qb = 32'd0; v.sa = 32'd0; v.imm = 32'd0;
        v.alu = 32'd0; v.rdata = 32'd0;
        return v;
    endfunction

    // Drive one vector, let one rising edge consume it, return just after.
    task automatic applyStimulus(input StimVec_t v);
        rst = v.rst; id_wir = v.wir; id_sela = v.sela; id_selb = v.selb;
        id_wreg = v.wreg; id_m2reg = v.m2reg; id_wmem = v.wmem;
        id_aluc = v.aluc; id_wn = v.wn; id_rt = v.rt; id_rs = v.rs;
        id_qa = v.qa; id_qb = v.qb; id_sa = v.sa; id_imm = v.imm;
        ex_alu_r = v.alu; mem_rdata = v.rdata;
        @(posedge clk);
        #1;
    endtask

    // History model: on each edge, work out what enters EX from the values
    // the older instructions will write back, then record it.
    always @(posedge clk) begin : modelProc
        Stage_t cap, memE, wbE, zero;
        logic [31:0] memFwd, wbData, regA, regB;
        int n;
        zero = '{wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, aluc: 4'd0, wn: 5'd0,
                 a: 32'd0, b: 32'd0, sdata: 32'd0};
        if (rst) begin
            hist.delete(); aluH.delete(); rdH.delete();
            for (int i = 0; i < 3; i++) begin
                hist.push_back(zero); aluH.push_back(32'd0); rdH.push_back(32'd0);
            end
            checkEnable = 1'b1;
        end else begin
            n = hist.size();
            memE = hist[n-2];
            wbE  = hist[n-3];
            memFwd = memE.m2reg ? mem_rdata : aluH[n-1];
            wbData = wbE.m2reg ? rdH[n-1] : aluH[n-2];
            regA = id_qa;
            regB = id_qb;
`ifdef FWD_WB_EN
            if (wbE.wreg && wbE.wn == id_rs) regA = wbData;
            if (wbE.wreg && wbE.wn == id_rt) regB = wbData;
`endif
            cap = zero;
            if (id_wir) begin
                cap.wreg = id_wreg; cap.m2reg = id_m2reg; cap.wmem = id_wmem;
                cap.aluc = id_aluc; cap.wn = id_wn;
                cap.a = (id_sela == 2'd0) ? regA : (id_sela == 2'd1) ? id_sa :
                        (id_sela == 2'd2) ? ex_alu_r : memFwd;
                cap.b = (id_selb == 2'd0) ? regB : (id_selb == 2'd1) ? id_imm :
                        (id_selb == 2'd2) ? ex_alu_r : memFwd;
                cap.sdata = (memE.wreg && memE.wn == id_rt) ? memFwd : regB;
            end
            hist.push_back(cap);
            aluH.push_back(ex_alu_r);
            rdH.push_back(mem_rdata);
        end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin : compareProc
        Stage_t ex, me, wb;
        int n;
        if (checkEnable) begin
            n  = hist.size();
            ex = hist[n-1];
            me = hist[n-2];
            wb = hist[n-3];
            checkOutput("ex_a", ex_a, ex.a);
            checkOutput("ex_b", ex_b, ex.b);
            checkOutput("ex_aluc", 32'(ex_aluc), 32'(ex.aluc));
            checkOutput("ex_sdata", ex_sdata, ex.sdata);
            checkOutput("EXwreg", 32'(EXwreg), 32'(ex.wreg));
            checkOutput("EXm2reg", 32'(EXm2reg), 32'(ex.m2reg));
            checkOutput("EXwn", 32'(EXwn), 32'(ex.wn));
            checkOutput("mem_wmem", 32'(mem_wmem), 32'(me.wmem));
            checkOutput("mem_addr", mem_addr, aluH[n-1]);
            checkOutput("mem_sdata", mem_sdata, me.sdata);
            checkOutput("MEMwreg", 32'(MEMwreg), 32'(me.wreg));
            checkOutput("MEMwn", 32'(MEMwn), 32'(me.wn));
            checkOutput("wb_wreg", 32'(wb_wreg), 32'(wb.wreg));
            checkOutput("wb_wn", 32'(wb_wn), 32'(wb.wn));
            checkOutput("wb_wdata", wb_wdata, wb.m2reg ? rdH[n-1] : aluH[n-2]);
        end
    end

    initial begin : stimProc
        StimVec_t v;

        // Reset with arbitrary inputs held for two cycles
        v = nopVec();
        v.rst = 1'b1; v.wreg = 1'b1; v.wn = 5'd17; v.qa = 32'hDEAD_BEEF;
        v.alu = 32'h1357_9BDF; v.rdata = 32'h2468_ACE0; v.aluc = 4'd9;
        applyStimulus(v);
        applyStimulus(v);
        checkOutput("rst_ex_a", ex_a, 32'd0);
        checkOutput("rst_EXwn", 32'(EXwn), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_wb_wdata", wb_wdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(nopVec());
            checkOutput("post_rst_wb_wreg", 32'(wb_wreg), 32'd0);
        end

        // Straight flow: 5 + 7 into r3
        v = nopVec();
        v.sela = 2'b00; v.selb = 2'b01; v.qa = 32'd5; v.imm = 32'd7;
        v.aluc = 4'd2; v.wreg = 1'b1; v.wn = 5'd3; v.alu = 32'h0BAD;
        applyStimulus(v);
        checkOutput("flow_ex_a", ex_a, 32'd5);
        checkOutput("flow_ex_b", ex_b, 32'd7);
        v = nopVec(); v.alu = 32'd12;
        applyStimulus(v);
        checkOutput("flow_mem_addr", mem_addr, 32'd12);
        v = nopVec(); v.rdata = 32'hFFFF_0000;
        applyStimulus(v);
        checkOutput("flow_wb_wreg", 32'(wb_wreg), 32'd1);
        checkOutput("flow_wb_wn", 32'(wb_wn), 32'd3);
        checkOutput("flow_wb_wdata", wb_wdata, 32'd12);

        // EX forward overrides the register-file value
        v = nopVec();
        v.sela = 2'b10; v.alu = 32'h1234; v.qa = 32'hFFFF; v.wreg = 1'b1; v.wn = 5'd8;
        applyStimulus(v);
        checkOutput("exfwd_ex_a", ex_a, 32'h1234);

        // MEM forward of a load result
        v = nopVec();
        v.wreg = 1'b1; v.m2reg = 1'b1; v.wn = 5'd5; v.sela = 2'b01; v.sa = 32'd3;
        v.selb = 2'b01; v.imm = 32'h80;
        applyStimulus(v);
        v = nopVec(); v.alu = 32'h80;
        applyStimulus(v);
        checkOutput("load_MEMwn", 32'(MEMwn), 32'd5);
        v = nopVec(); v.selb = 2'b11; v.rdata = 32'hAA55; v.qb = 32'h7777;
        applyStimulus(v);
        checkOutput("memfwd_load_ex_b", ex_b, 32'hAA55);
        checkOutput("load_wb_wdata", wb_wdata, 32'hAA55);

        // MEM forward of an ALU result, plus store-data forwarding
        v = nopVec(); v.wreg = 1'b1; v.wn = 5'd9;
        applyStimulus(v);
        v = nopVec(); v.alu = 32'h40;
        applyStimulus(v);
        v = nopVec(); v.selb = 2'b11; v.rdata = 32'hDEAD; v.rt = 5'd9;
        v.qb = 32'h1111; v.wmem = 1'b1;
        applyStimulus(v);
        checkOutput("memfwd_alu_ex_b", ex_b, 32'h40);
        checkOutput("sdata_fwd", ex_sdata, 32'h40);
        v = nopVec(); v.rt = 5'd10; v.qb = 32'h2222; v.wmem = 1'b1;
        applyStimulus(v);
        checkOutput("sdata_nofwd", ex_sdata, 32'h2222);
        checkOutput("store_mem_sdata", mem_sdata, 32'h40);
        checkOutput("store_mem_wmem", 32'(mem_wmem), 32'd1);

        // Stall: bubble injected, older instruction keeps moving
        v = nopVec(); v.wreg = 1'b1; v.wn = 5'd6; v.qa = 32'h66;
        applyStimulus(v);
        v = nopVec(); v.wir = 1'b0; v.wreg = 1'b1; v.wn = 5'd7; v.aluc = 4'd5;
        v.qa = 32'h77; v.alu = 32'h600;
        applyStimulus(v);
        checkOutput("stall_EXwreg", 32'(EXwreg), 32'd0);
        checkOutput("stall_EXwn", 32'(EXwn), 32'd0);
        checkOutput("stall_ex_aluc", 32'(ex_aluc), 32'd0);
        checkOutput("stall_MEMwn", 32'(MEMwn), 32'd6);
        applyStimulus(v);
        checkOutput("stall2_MEMwreg", 32'(MEMwreg), 32'd0);
        checkOutput("stall2_wb_wn", 32'(wb_wn), 32'd6);
        v.wir = 1'b1;
        applyStimulus(v);
        checkOutput("retry_EXwn", 32'(EXwn), 32'd7);
        checkOutput("retry_ex_a", ex_a, 32'h77);

        // Reset during a stall clears everything
        v.wir = 1'b0; v.rst = 1'b1; v.alu = 32'h5A5A;
        applyStimulus(v);
        checkOutput("rststall_EXwreg", 32'(EXwreg), 32'd0);
        checkOutput("rststall_mem_addr", mem_addr, 32'd0);
        applyStimulus(nopVec());

        // Write-back bypass (active only with FWD_WB_EN)
        v = nopVec(); v.wreg = 1'b1; v.wn = 5'd4;
        applyStimulus(v);
        v = nopVec(); v.alu = 32'd9;
        applyStimulus(v);
        applyStimulus(nopVec());
        checkOutput("wbb_wb_wn", 32'(wb_wn), 32'd4);
        checkOutput("wbb_wb_wdata", wb_wdata, 32'd9);
        v = nopVec(); v.sela = 2'b00; v.qa = 32'd0; v.rs = 5'd4; v.rt = 5'd4; v.qb = 32'd0;
        applyStimulus(v);
`ifdef FWD_WB_EN
        checkOutput("wbb_ex_a", ex_a, 32'd9);
        checkOutput("wbb_sdata", ex_sdata, 32'd9);
`else
        checkOutput("wbb_ex_a", ex_a, 32'd0);
        checkOutput("wbb_sdata", ex_sdata, 32'd0);
`endif

        // Mixed traffic with small register numbers so forwarding paths hit
        for (int i = 0; i < 40; i++) begin
            v.rst = 1'b0;
            v.wir = ($urandom_range(0, 3) != 0);
            v.sela = 2'($urandom_range(0, 3));
            v.selb = 2'($urandom_range(0, 3));
            v.wreg = 1'($urandom_range(0, 1));
            v.m2reg = 1'($urandom_range(0, 1));
            v.wmem = 1'($urandom_range(0, 1));
            v.aluc = 4'($urandom_range(0, 15));
            v.wn = 5'($urandom_range(0, 3));
            v.rt = 5'($urandom_range(0, 3));
            v.rs = 5'($urandom_range(0, 3));
            v.qa = $urandom; v.qb = $urandom; v.sa = $urandom; v.imm = $urandom;
            v.alu = $urandom; v.rdata = $urandom;
            applyStimulus(v);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
